// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - unloads an NWORDS result from core RAM as a stream, two words per read cycle
module result_unloader #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 64,
    parameter int NWORDS = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              core_busy,
    input  logic [WORD_W-1:0] rd_data1,
    input  logic [WORD_W-1:0] rd_data2,
    output logic              ref_mode,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int NPAIRS = NWORDS / 2;
    localparam int K_W    = $clog2(NPAIRS) + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NPAIRS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_CAPTURE,
        S_SEND0,
        S_SEND1,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [K_W-1:0]    k;
    logic [WORD_W-1:0] buf0;
    logic [WORD_W-1:0] buf1;

    // Addresses are registered on the edge entering ISSUE, so they are computed
    // from the pair index that ISSUE will work on (k+1 when coming from SEND1).
    logic [K_W-1:0]    issue_k;
    logic [ADDR_W-1:0] addr_even;
    logic [ADDR_W-1:0] addr_odd;

    always_comb begin
        issue_k   = (state == S_SEND1) ? (k + K_W'(1)) : k;
        addr_even = base_q + ADDR_W'({issue_k, 1'b0});
        addr_odd  = addr_even + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            base_q    <= '0;
            k         <= '0;
            buf0      <= '0;
            buf1      <= '0;
            ref_mode  <= 1'b0;
            raddr1    <= '0;
            raddr2    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!core_busy) begin
                        raddr1   <= addr_even;
                        raddr2   <= addr_odd;
                        ref_mode <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    buf0      <= rd_data1;
                    buf1      <= rd_data2;
                    ref_mode  <= 1'b0;
                    out_valid <= 1'b1;
                    out_data  <= rd_data1;
                    out_last  <= 1'b0;
                    state     <= S_SEND0;
                end
                S_SEND0: begin
                    if (out_ready) begin
                        out_data <= buf1;
                        out_last <= (k == K_LAST);
                        state    <= S_SEND1;
                    end
                end
                S_SEND1: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (k == K_LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            k        <= issue_k;
                            raddr1   <= addr_even;
                            raddr2   <= addr_odd;
                            ref_mode <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - table-driven self-checking bench for result_unloader
module tb_result_unloader;

    localparam int ADDR_W = 10;
    localparam int WORD_W = 64;
    localparam int NWORDS = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              core_busy = 1'b0;
    logic [WORD_W-1:0] rd_data1 = '0;
    logic [WORD_W-1:0] rd_data2 = '0;
    logic              ref_mode;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;

    result_unloader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .core_busy (core_busy),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .ref_mode  (ref_mode),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Core RAM model: each word holds its own address, one cycle read latency
    always @(posedge clk) begin
        rd_data1 <= {{(WORD_W-ADDR_W){1'b0}}, raddr1};
        rd_data2 <= {{(WORD_W-ADDR_W){1'b0}}, raddr2};
    end

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                busy_hold;
        bit                stall;
        int                inj;
        int                abort;
        int                exp_first;
        int                exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {39'd0, ref_mode, raddr1, raddr2, out_valid, out_data, out_last, busy, done}, 128'd0);
    endtask

    task automatic run_vec(input int vi);
        vec_t              v;
        int                cyc;
        int                widx;
        int                first_seen;
        int                done_cyc;
        int                done_cnt;
        bit                gate_ok;
        bit                stable_ok;
        bit                data_ok;
        bit                prev_stall;
        logic [WORD_W-1:0] prev_data;
        logic              prev_last;
        logic [ADDR_W-1:0] r1_before;
        logic [ADDR_W-1:0] exp_addr;
        bit                finished;
        v = vecs[vi];
        @(negedge clk);
        core_busy = (v.busy_hold > 0);
        base_addr = v.base;
        start     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        cyc        = 0;
        widx       = 0;
        first_seen = -1;
        done_cyc   = -1;
        done_cnt   = 0;
        gate_ok    = 1'b1;
        stable_ok  = 1'b1;
        data_ok    = 1'b1;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        r1_before  = raddr1;
        finished   = 1'b0;
        while (!finished && cyc < 3000) begin
            if (cyc == v.busy_hold) core_busy = 1'b0;
            if (cyc >= 1 && cyc <= v.busy_hold)
                if (ref_mode !== 1'b0 || busy !== 1'b1 || raddr1 !== r1_before) gate_ok = 1'b0;
            if (out_valid === 1'b1 && first_seen < 0) first_seen = cyc;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                stable_ok = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (v.stall) out_ready = ($urandom_range(0, 9) < 3);
            else         out_ready = 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                exp_addr = v.base + ADDR_W'(widx);
                if (widx >= NWORDS || out_data !== {{(WORD_W-ADDR_W){1'b0}}, exp_addr}
                    || out_last !== (widx == NWORDS - 1)) begin
                    if (data_ok)
                        $display("FAIL vec%0d beat%0d: got data %0h last %0b expected data %0h last %0b",
                                 vi, widx, out_data, out_last, exp_addr, (widx == NWORDS - 1));
                    data_ok = 1'b0;
                end
                widx++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (cyc == v.inj) begin
                start     = 1'b1;
                base_addr = 10'h200;
            end else begin
                start = 1'b0;
            end
            if (v.abort >= 0 && widx == v.abort) finished = 1'b1;
            else if (done_cyc >= 0 && cyc > done_cyc) begin
                check($sformatf("vec%0d idle_after_done", vi), {126'd0, busy, out_valid}, 128'd0);
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (!data_ok) fails++;
        check($sformatf("vec%0d first_valid_cycle", vi), 128'(first_seen), 128'(v.exp_first));
        check($sformatf("vec%0d busy_gate", vi), 128'(gate_ok), 128'd1);
        check($sformatf("vec%0d stall_stable", vi), 128'(stable_ok), 128'd1);
        if (v.abort >= 0) begin
            check($sformatf("vec%0d beats_before_abort", vi), 128'(widx), 128'(v.abort));
            #2;
            rst_n = 1'b0;
            #1;
            check_all_zero($sformatf("vec%0d midrun_reset", vi));
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            check($sformatf("vec%0d beat_count", vi), 128'(widx), 128'(NWORDS));
            check($sformatf("vec%0d done_pulses", vi), 128'(done_cnt), 128'd1);
            if (v.exp_done >= 0)
                check($sformatf("vec%0d done_cycle", vi), 128'(done_cyc), 128'(v.exp_done));
        end
    endtask

    initial begin
        //            base     hold stall inj abort first done
        vecs[0] = '{10'h100,  0,  1'b0, -1, -1,  3,  49};
        vecs[1] = '{10'h100,  50, 1'b0, -1, -1,  53, 99};
        vecs[2] = '{10'h080,  0,  1'b1, -1, -1,  3,  -1};
        vecs[3] = '{10'h3FC,  0,  1'b0, -1, -1,  3,  49};
        vecs[4] = '{10'h100,  0,  1'b0,  8, -1,  3,  49};
        vecs[5] = '{10'h100,  0,  1'b0, 49, -1,  3,  49};
        vecs[6] = '{10'h100,  0,  1'b0, -1,  7,  3,  -1};
        vecs[7] = '{10'h040,  0,  1'b0, -1, -1,  3,  49};

        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_release_idle");

        for (int i = 0; i < 8; i++) run_vec(i);

        repeat (3) @(posedge clk);
        #1;
        check("final_idle", {126'd0, busy, out_valid}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, width of core RAM read addresses.
REQ-002 SHALL have parameter WORD_W, default 64, width of one RAM word.
REQ-003 SHALL have parameter NWORDS, default 24, result length in words; even, >= 2.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to unload a result.
REQ-008 base_addr  input  ADDR_W  first result address, sampled with accepted start.
REQ-009 core_busy  input  1  pairing core is executing; no reads allowed while 1.
REQ-010 rd_data1, rd_data2  input  WORD_W each  core read data; valid one cycle after address presentation.
REQ-011 ref_mode  output  1  requests core input mode REF_RESULT.
REQ-012 raddr1, raddr2  output  ADDR_W each  core read addresses, registered.
REQ-013 out_valid, out_ready  output/input  1 each  result stream handshake.
REQ-014 out_data  output  WORD_W  result word; out_last  output  1  marks word NWORDS-1.
REQ-015 busy  output  1  high in any state but IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, ISSUE, CAPTURE, SEND0, SEND1, DONE.
REQ-017 IDLE: start=1 latches base_addr, clears pair counter k, goes to WAIT; start in any other state is ignored.
REQ-018 WAIT: leaves to ISSUE on first edge sampling core_busy=0; stays otherwise, indefinitely.
REQ-019 ISSUE: raddr1=base+2k, raddr2=base+2k+1, modulo 2^ADDR_W (wrap, no error); next CAPTURE.
REQ-020 CAPTURE: registers rd_data1 into buf0, rd_data2 into buf1; next SEND0.
REQ-021 ref_mode SHALL be 1 in ISSUE and CAPTURE only; raddr1/raddr2 hold last value elsewhere.
REQ-022 SEND0: out_valid=1, out_data=buf0, out_last=0; on out_ready=1 go to SEND1.
REQ-023 SEND1: out_valid=1, out_data=buf1, out_last=(k==NWORDS/2-1); on out_ready=1 go to DONE if last else k+1 and ISSUE.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; no word dropped or duplicated.
REQ-025 out_valid SHALL be 0 in IDLE, WAIT, ISSUE, CAPTURE, DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; start sampled in DONE is ignored.
REQ-027 Latency: start accepted at edge N with core_busy=0 gives out_valid=1 after edge N+3; with out_ready held 1, each pair takes 4 cycles, done after edge N+2*NWORDS+1.
REQ-028 Words SHALL emerge in address order base..base+NWORDS-1.
REQ-029 core_busy rising after WAIT is not rechecked; the unload continues.
REQ-030 Pair counter width ceil(log2(NWORDS/2))+1; no overflow for legal NWORDS.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and all outputs to 0 (ref_mode, raddr1, raddr2, out_valid, out_data, out_last, busy, done), buffers and k to 0.
REQ-032 Reset mid-unload SHALL abandon the transfer; next accepted start restarts from word 0.

Verification
REQ-033 Reset: assert rst_n=0 mid-cycle -> all outputs 0 without a clock edge.
REQ-034 Nominal: base_addr=0x100, core_busy=0, out_ready=1, memory returns data=addr -> 24 beats 0x100..0x117, out_last only on 0x117, first valid at N+3, one done pulse at N+49.
REQ-035 Busy gate: core_busy=1 for 50 cycles after start -> ref_mode=0, raddr unchanged, busy=1 until busy falls; then REQ-034 sequence.
REQ-036 Backpressure: out_ready random 30% high -> out_data stable while stalled, exact 24-word sequence, no duplicates.
REQ-037 Wrap: ADDR_W=10, base_addr=0x3FC -> addresses 0x3FC..0x3FF then 0x000..0x013.
REQ-038 Interruptions: start pulsed during SEND1 -> ignored; rst_n=0 at beat 7 then new start base=0x040 -> stream restarts at 0x040.
